pipelined_data_memory: RTL and testbench

PIPELINED_DATA_MEMORY -- requirements
Module: pipelined_data_memory

---
 rtl/pdm_pkg.sv | 6 +
 rtl/pdm_rsp_pipe.sv | 40 ++++
 rtl/pipelined_data_memory.sv | 77 +++++++
 tb/tb_pipelined_data_memory.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared state type and read-latency limits for pipelined_data_memory
package pdm_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/pdm_rsp_pipe.sv
// pdm_rsp_pipe: RD_LAT-stage response delay line carrying valid, data and err
module pdm_rsp_pipe #(
  parameter int RD_LAT = 2,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  logic [RD_LAT-1:0] v, e;
  logic [DATA_W-1:0] d [RD_LAT];
  logic [RD_LAT:0] sv, se;
  logic [DATA_W-1:0] sd [RD_LAT+1];
  assign sv = {v, in_valid};
  assign se = {e, in_err};
  // stage i is fed by stage i-1, stage 0 by the inputs
  always_comb begin
    sd[0] = in_data;
    for (int i = 0; i < RD_LAT; i++) sd[i+1] = d[i];
  end
  // data only moves with a valid so the tail holds the last response; err is masked by valid
  always_ff @(posedge CLK)
    if (RST) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v <= sv[RD_LAT-1:0];
      e <= sv[RD_LAT-1:0] & se[RD_LAT-1:0];
      for (int i = 0; i < RD_LAT; i++) if (sv[i]) d[i] <= sd[i];
    end
  assign out_valid = sv[RD_LAT];
  assign out_data  = sd[RD_LAT];
  assign out_err   = se[RD_LAT];
endmodule

// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: byte-enabled word memory with self-clearing init and fixed-latency reads
module pipelined_data_memory import pdm_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Req_Valid,
  output logic                Req_Ready,
  input  logic                Req_Write,
  input  logic [ADDR_W-1:0]   Req_Addr,
  input  logic [DATA_W-1:0]   Req_WD,
  input  logic [DATA_W/8-1:0] Req_BE,
  output logic                Rsp_Valid,
  output logic [DATA_W-1:0]   Rsp_RD,
  output logic                Rsp_Err,
  output logic                Init_Busy
);
  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(DEPTH);
  if (DATA_W < 8 || DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8, minimum 8");
  end
  if (DEPTH < 2 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("DEPTH must be in 2..2**ADDR_W");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..4");
  end
  state_t state;
  logic [IW-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, in_range, we;
  logic [IW-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [NB-1:0] be;
  assign acc = Req_Valid && Req_Ready && !RST;
  assign in_range = {1'b0, Req_Addr} < (ADDR_W+1)'(DEPTH);
  // the single write port is shared between the clear sweep and accepted in-range writes
  always_comb begin
    we = !RST && (state == INIT || (acc && Req_Write && in_range));
    wa = state == INIT ? clr_cnt : Req_Addr[IW-1:0];
    wd = state == INIT ? '0 : Req_WD;
    be = state == INIT ? '1 : Req_BE;
  end
  // INIT sweeps addresses 0..DEPTH-1 one per cycle, then RUN accepts requests
  always_ff @(posedge CLK)
    if (RST) begin
      state     <= INIT;
      clr_cnt   <= '0;
      Req_Ready <= 1'b0;
      Init_Busy <= 1'b1;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IW'(DEPTH - 1)) begin
        state     <= RUN;
        Req_Ready <= 1'b1;
        Init_Busy <= 1'b0;
      end
    end
  // per-lane write so disabled byte lanes keep their contents
  always_ff @(posedge CLK)
    if (we)
      for (int i = 0; i < NB; i++) if (be[i]) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
  pdm_rsp_pipe #(.RD_LAT(RD_LAT), .DATA_W(DATA_W)) u_rsp (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (acc && !Req_Write),
    .in_data  (in_range ? mem[Req_Addr[IW-1:0]] : '0),
    .in_err   (!in_range),
    .out_valid(Rsp_Valid),
    .out_data (Rsp_RD),
    .out_err  (Rsp_Err)
  );
endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb_pipelined_data_memory: two instances (DEPTH 256 and 200) against a cycle-level behavioural model
module tb_pipelined_data_memory;
  localparam int LAT = 2;
  logic CLK = 0;
  logic RST = 1;
  logic vld = 0, wr = 0;
  logic [7:0] addr = 0;
  logic [15:0] wd = 0;
  logic [1:0] be = 0;
  logic [1:0] rdy, bsy, rv, rer;
  logic [15:0] rrd [2];
  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  pipelined_data_memory u0 (
    .CLK(CLK), .RST(RST), .Req_Valid(vld), .Req_Ready(rdy[0]), .Req_Write(wr),
    .Req_Addr(addr), .Req_WD(wd), .Req_BE(be), .Rsp_Valid(rv[0]), .Rsp_RD(rrd[0]),
    .Rsp_Err(rer[0]), .Init_Busy(bsy[0])
  );
  pipelined_data_memory #(.DEPTH(200)) u1 (
    .CLK(CLK), .RST(RST), .Req_Valid(vld), .Req_Ready(rdy[1]), .Req_Write(wr),
    .Req_Addr(addr), .Req_WD(wd), .Req_BE(be), .Rsp_Valid(rv[1]), .Rsp_RD(rrd[1]),
    .Rsp_Err(rer[1]), .Init_Busy(bsy[1])
  );

  function automatic int dep(int d);
    return d == 0 ? 256 : 200;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: memory image, init progress, and a response calendar keyed by due cycle
  int unsigned tick = 0;
  bit seen = 0;
  bit run [2];
  int cnt [2];
  logic [15:0] mm [2][256];
  bit cv [2][8];
  logic [15:0] cd [2][8];
  bit ce [2][8];
  logic [15:0] last [2];

  initial forever begin
    int s;
    @(posedge CLK);
    tick++;
    for (int d = 0; d < 2; d++) begin
      if (RST) begin
        seen = 1;
        run[d] = 0;
        cnt[d] = 0;
        last[d] = 0;
        for (int k = 0; k < 8; k++) cv[d][k] = 0;
      end else if (!run[d]) begin
        mm[d][cnt[d]] = 0;
        cnt[d]++;
        if (cnt[d] == dep(d)) run[d] = 1;
      end else if (vld && wr) begin
        if (int'(addr) < dep(d))
          for (int b = 0; b < 2; b++) if (be[b]) mm[d][addr][b*8 +: 8] = wd[b*8 +: 8];
      end else if (vld) begin
        s = (tick + LAT - 1) % 8;
        cv[d][s] = 1;
        cd[d][s] = int'(addr) < dep(d) ? mm[d][addr] : 16'h0;
        ce[d][s] = int'(addr) >= dep(d);
      end
    end
    #1;
    if (seen)
      for (int d = 0; d < 2; d++) begin
        s = tick % 8;
        chk($sformatf("u%0d.req_ready", d), rdy[d], run[d]);
        chk($sformatf("u%0d.init_busy", d), bsy[d], !run[d]);
        chk($sformatf("u%0d.rsp_valid", d), rv[d], cv[d][s]);
        if (cv[d][s]) last[d] = cd[d][s];
        chk($sformatf("u%0d.rsp_rd", d), rrd[d], last[d]);
        chk($sformatf("u%0d.rsp_err", d), rer[d], cv[d][s] && ce[d][s]);
        cv[d][s] = 0;
      end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input bit w, input logic [7:0] a, input logic [15:0] dat, input logic [1:0] b);
    vld = 1; wr = w; addr = a; wd = dat; be = b;
  endtask

  task automatic idle();
    vld = 0; wr = 0;
  endtask

  task automatic wr_op(input logic [7:0] a, input logic [15:0] dat, input logic [1:0] b);
    put(1, a, dat, b);
    step();
    idle();
  endtask

  task automatic rd_chk(input int d, input logic [7:0] a, input logic [15:0] exp,
                        input bit experr, input string name);
    int lat;
    lat = 1;
    put(0, a, 16'h0, 2'b00);
    step();
    idle();
    while (!rv[d] && lat < 10) begin
      step();
      lat++;
    end
    chk({name, ".valid"}, rv[d], 1);
    chk({name, ".lat"}, lat, LAT);
    chk({name, ".rd"}, rrd[d], exp);
    chk({name, ".err"}, rer[d], experr);
  endtask

  initial begin
    int busy, cyc, n, spur;
    logic [15:0] got [3];
    int at [3];
    busy = 0; cyc = 1; n = 0; spur = 0;
    step();
    step();
    RST = 0;
    put(0, 8'hFF, 16'h0, 2'b00);
    while (!rdy[0] && cyc < 400) begin
      busy++;
      step();
      cyc++;
    end
    chk("init_busy_cycles", busy, 256);
    chk("ready_rise_cycle", cyc, 257);
    rd_chk(0, 8'hFF, 16'h0000, 0, "init_rd_ff");
    wr_op(8'h10, 16'hBEEF, 2'b11);
    wr_op(8'h10, 16'h12AB, 2'b10);
    rd_chk(0, 8'h10, 16'h12EF, 0, "be_merge");
    wr_op(8'h10, 16'hFFFF, 2'b00);
    rd_chk(0, 8'h10, 16'h12EF, 0, "be_zero");
    wr_op(8'h20, 16'hA5A5, 2'b11);
    rd_chk(0, 8'h20, 16'hA5A5, 0, "wr_then_rd");
    rd_chk(1, 8'hC8, 16'h0000, 1, "oor_rd");
    wr_op(8'hC8, 16'h5555, 2'b11);
    rd_chk(1, 8'h00, 16'h0000, 0, "oor_wr_rd0");
    rd_chk(1, 8'hC8, 16'h0000, 1, "oor_wr_dropped");
    rd_chk(0, 8'hC8, 16'h5555, 0, "u0_c8");
    wr_op(8'h01, 16'h1111, 2'b11);
    wr_op(8'h02, 16'h2222, 2'b11);
    wr_op(8'h03, 16'h3333, 2'b11);
    for (int k = 0; k < 10; k++) begin
      if (k < 3) put(0, 8'(k + 1), 16'h0, 2'b00);
      else idle();
      step();
      if (rv[0]) begin
        if (n < 3) begin
          got[n] = rrd[0];
          at[n] = k;
        end
        n++;
      end
    end
    chk("b2b_count", n, 3);
    if (n == 3) begin
      chk("b2b_gap1", at[1], at[0] + 1);
      chk("b2b_gap2", at[2], at[0] + 2);
      chk("b2b_d0", got[0], 16'h1111);
      chk("b2b_d1", got[1], 16'h2222);
      chk("b2b_d2", got[2], 16'h3333);
    end
    wr_op(8'h30, 16'h7777, 2'b11);
    put(0, 8'h30, 16'h0, 2'b00);
    step();
    idle();
    RST = 1;
    step();
    RST = 0;
    chk("rst_busy", bsy[0], 1);
    chk("rst_ready", rdy[0], 0);
    cyc = 0;
    while (!rdy[0] && cyc < 400) begin
      if (rv[0]) spur++;
      step();
      cyc++;
    end
    chk("rst_no_rsp", spur, 0);
    chk("rst_reinit_cycles", cyc, 256);
    rd_chk(0, 8'h30, 16'h0000, 0, "post_rst_30");
    rd_chk(0, 8'h10, 16'h0000, 0, "post_rst_10");
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
